// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared constants, entry type and PC helper for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    localparam int PC_MAX_W = 64;

    // Entry layout at the core's native 32-bit PC width.
    typedef struct packed {
        logic [31:0]        pc4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Works on the widest supported PC; callers size in and out with casts.
    function automatic logic [PC_MAX_W-1:0] pc_align(input logic [PC_MAX_W-1:0] pc);
        return {pc[PC_MAX_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_prefetch_fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO with flush, parametrised by depth and entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0],
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full queue is accepted only when a pop frees the slot.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_prefetch.sv
// ============================================================================
// Module      : ifetch_prefetch
// Description : PC generator, in-order imem interface and prefetch queue for ID.
//               Optional performance counters enabled by IFETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc4,
    input  logic               id_ready,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped,
    output logic [31:0]        perf_stall,
`endif
    output logic [CW-1:0]      q_count
);

    typedef struct packed {
        logic [XLEN-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
    } q_entry_t;

    typedef logic [XLEN-1:0] tag_t;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic            w_fire;
    logic            w_rsp;
    logic            w_discard;
    logic            w_enq;
    logic            w_deq;
    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_count;
    logic            w_q_empty;
    logic            w_q_full;
    q_entry_t        w_head;
    q_entry_t        w_new_entry;
    tag_t            w_tag_head;
    logic [CW-1:0]   w_tag_count;
    logic            w_tag_empty;
    logic            w_tag_full;
    logic            w_unused_flags;

    // Credit covers queued plus in-flight fetches so a response always has a slot.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // With nothing outstanding a response is stale (e.g. issued before reset).
    assign w_rsp     = imem_rsp_valid && (r_outstanding != '0);
    assign w_discard = w_rsp && ((r_drop != '0) || redirect_valid);
    assign w_enq     = w_rsp && (r_drop == '0) && !redirect_valid;

    assign id_valid    = !reset && !w_q_empty;
    assign id_instr    = w_head.instr;
    assign id_pc4      = w_head.pc4;
    assign q_count     = reset ? '0 : w_count;
    assign w_deq       = id_valid && id_ready;
    assign w_new_entry = '{pc4: w_tag_head, instr: imem_rsp_data};

    // Dropped responses never pop a tag: their tags went with the redirect flush.
    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (tag_t)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (w_fire),
        .push_data (r_pc + XLEN'(PC_STEP)),
        .pop       (w_enq),
        .head      (w_tag_head),
        .count     (w_tag_count),
        .empty     (w_tag_empty),
        .full      (w_tag_full)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (q_entry_t)
    ) u_prefetch_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (w_enq),
        .push_data (w_new_entry),
        .pop       (w_deq),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_q_empty),
        .full      (w_q_full)
    );

    assign w_unused_flags = ^{w_tag_count, w_tag_empty, w_tag_full, w_q_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_rsp);
            if (redirect_valid) begin
                r_pc   <= XLEN'(pc_align(PC_MAX_W'(redirect_pc)));
                r_drop <= r_outstanding - CW'(w_rsp);
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + XLEN'(PC_STEP);
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_enq);
            r_perf_dropped <= r_perf_dropped + 32'(w_discard);
            r_perf_stall   <= r_perf_stall + 32'(id_valid && !id_ready);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

endmodule

`default_nettype wire
